// File: rtl/audio_fifo_pkg.sv
// Shared constants and helpers for the multichannel audio sample FIFO.
package audio_fifo_pkg;

  // Channel slot indices within a packed frame (ch0 in the low bits).
  localparam int unsigned CH_LEFT  = 0;
  localparam int unsigned CH_RIGHT = 1;

  // Default almost-full margin below DEPTH and default almost-empty level.
  localparam int unsigned AF_MARGIN  = 2;
  localparam int unsigned AE_DEFAULT = 2;

  // Width of a fill-level counter able to hold 0..depth inclusive.
  function automatic int unsigned level_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, fill-level and flag control for the sample FIFO. Requests that
// would overflow or underflow are not accepted and leave state untouched.
module fifo_ptr_ctrl import audio_fifo_pkg::*; #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - AF_MARGIN,
  parameter int unsigned AE_LEVEL = AE_DEFAULT,
  localparam int unsigned PtrW    = $clog2(DEPTH),
  localparam int unsigned LvlW    = level_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write_en,
  input  logic            read_en,
  output logic            wr_acc,
  output logic            rd_acc,
  output logic [PtrW-1:0] wr_ptr,
  output logic [PtrW-1:0] rd_ptr,
  output logic [LvlW-1:0] level,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty
);

  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
  localparam logic [LvlW-1:0] LvlAf   = LvlW'(AF_LEVEL);
  localparam logic [LvlW-1:0] LvlAe   = LvlW'(AE_LEVEL);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;

  // Flags decode straight from the registered level.
  always_comb begin
    full         = (level_q == LvlFull);
    empty        = (level_q == '0);
    almost_full  = (level_q >= LvlAf);
    almost_empty = (level_q <= LvlAe);
    wr_acc       = write_en & ~full;
    rd_acc       = read_en & ~empty;
  end

  // Next-state: pointers wrap naturally, level tracks net accepted traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign level  = level_q;

endmodule

// File: rtl/multich_sample_fifo.sv
// Multichannel audio sample FIFO: one NUM_CH-channel frame per entry.
// FWFT selects registered-read (0) or first-word-fall-through (1) output.
// Optional sticky overflow/underflow flags: define MCFIFO_ERR_FLAGS_EN.
module multich_sample_fifo import audio_fifo_pkg::*; #(
  parameter int unsigned WORDSIZE = 32,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - AF_MARGIN,
  parameter int unsigned AE_LEVEL = AE_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             write_en,
  input  logic                             read_en,
  input  logic [NUM_CH*WORDSIZE-1:0]       data_in,
`ifdef MCFIFO_ERR_FLAGS_EN
  input  logic                             err_clr,
  output logic                             overflow,
  output logic                             underflow,
`endif
  output logic [NUM_CH*WORDSIZE-1:0]       data_out,
  output logic                             out_valid,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic [level_width(DEPTH)-1:0]    level
);

  localparam int unsigned FrameW = NUM_CH * WORDSIZE;
  localparam int unsigned PtrW   = $clog2(DEPTH);

  logic              wr_acc, rd_acc;
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [FrameW-1:0] mem_q [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ptr_ctrl (
    .clk          (clk),
    .rst          (rst),
    .write_en     (write_en),
    .read_en      (read_en),
    .wr_acc       (wr_acc),
    .rd_acc       (rd_acc),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  // Frame storage; whole frames are written at once so channels stay aligned.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr] <= data_in;
  end

  if (FWFT == 0) begin : g_reg_read
    logic [FrameW-1:0] data_out_q;
    logic              out_valid_q;

    // Registered read: data appears one cycle after an accepted read.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_out_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= rd_acc;
        if (rd_acc) data_out_q <= mem_q[rd_ptr];
      end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
  end else begin : g_fwft
    // Head frame is always presented; read_en only pops it.
    assign data_out  = mem_q[rd_ptr];
    assign out_valid = ~empty;
  end

`ifdef MCFIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; a new event in the clear cycle keeps the flag set.
  always_comb begin
    overflow_d  = (overflow_q & ~err_clr) | (write_en & full);
    underflow_d = (underflow_q & ~err_clr) | (read_en & empty);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_multich_sample_fifo.sv
// Directed bench: a registered-read stereo FIFO (DEPTH 16) and a
// four-channel FWFT FIFO (DEPTH 4) share the clock and reset.
module tb_multich_sample_fifo;
  import audio_fifo_pkg::*;

  logic        clk;
  logic        rst;
  int          checks;
  int          errors;

  // Instance 0: defaults (32-bit, 2 ch, DEPTH 16, FWFT 0)
  logic        we0, re0;
  logic [63:0] din0, dout0;
  logic        ov0, full0, empty0, af0, ae0;
  logic [4:0]  lvl0;
  // Instance 1: 16-bit, 4 ch, DEPTH 4, FWFT 1
  logic        we1, re1;
  logic [63:0] din1, dout1;
  logic        ov1, full1, empty1, af1, ae1;
  logic [2:0]  lvl1;
`ifdef MCFIFO_ERR_FLAGS_EN
  logic        clr0, oflw0, uflw0, clr1, oflw1, uflw1;
`endif

  multich_sample_fifo u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .write_en     (we0),
    .read_en      (re0),
    .data_in      (din0),
`ifdef MCFIFO_ERR_FLAGS_EN
    .err_clr      (clr0),
    .overflow     (oflw0),
    .underflow    (uflw0),
`endif
    .data_out     (dout0),
    .out_valid    (ov0),
    .full         (full0),
    .empty        (empty0),
    .almost_full  (af0),
    .almost_empty (ae0),
    .level        (lvl0)
  );

  multich_sample_fifo #(
    .WORDSIZE (16),
    .NUM_CH   (4),
    .DEPTH    (4),
    .FWFT     (1)
  ) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .write_en     (we1),
    .read_en      (re1),
    .data_in      (din1),
`ifdef MCFIFO_ERR_FLAGS_EN
    .err_clr      (clr1),
    .overflow     (oflw1),
    .underflow    (uflw1),
`endif
    .data_out     (dout1),
    .out_valid    (ov1),
    .full         (full1),
    .empty        (empty1),
    .almost_full  (af1),
    .almost_empty (ae1),
    .level        (lvl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one clock of stimulus on instance 0, then sample 1 time unit after the edge.
  task automatic cyc0(input logic we, input logic re, input logic [63:0] din);
    we0 = we; re0 = re; din0 = din;
    @(posedge clk); #1;
    we0 = 1'b0; re0 = 1'b0;
  endtask

  task automatic cyc1(input logic we, input logic re, input logic [63:0] din);
    we1 = we; re1 = re; din1 = din;
    @(posedge clk); #1;
    we1 = 1'b0; re1 = 1'b0;
  endtask

  function automatic logic [63:0] fa(input int i);
    logic [63:0] f;
    f = '0;
    f[CH_LEFT*32  +: 32] = 32'(i);
    f[CH_RIGHT*32 +: 32] = 32'h1000 + 32'(i);
    return f;
  endfunction

  function automatic logic [63:0] fc(input int i);
    return {32'h2000 + 32'(i), 32'hA000 + 32'(i)};
  endfunction

  function automatic logic [63:0] ff(input int i);
    return {32'h3000 + 32'(i), 32'h0000_0F00 + 32'(i)};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    we0 = 0; re0 = 0; din0 = '0;
    we1 = 0; re1 = 0; din1 = '0;
`ifdef MCFIFO_ERR_FLAGS_EN
    clr0 = 0; clr1 = 0;
`endif
    #12;
    chk("rst_level", 64'(lvl0), 64'd0);
    chk("rst_empty", 64'(empty0), 64'd1);
    chk("rst_full", 64'(full0), 64'd0);
    chk("rst_ae", 64'(ae0), 64'd1);
    chk("rst_af", 64'(af0), 64'd0);
    chk("rst_valid", 64'(ov0), 64'd0);
    chk("rst_dout", dout0, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill to full; almost_full from level 14, almost_empty up to level 2
    for (int i = 0; i < 16; i++) begin
      cyc0(1'b1, 1'b0, fa(i));
      chk("fill_level", 64'(lvl0), 64'(i + 1));
      chk("fill_af", 64'(af0), 64'((i + 1) >= 14));
      chk("fill_ae", 64'(ae0), 64'((i + 1) <= 2));
    end
    chk("full_flag", 64'(full0), 64'd1);
    cyc0(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("drop_wr_level", 64'(lvl0), 64'd16);
    chk("drop_wr_full", 64'(full0), 64'd1);
`ifdef MCFIFO_ERR_FLAGS_EN
    chk("overflow_set", 64'(oflw0), 64'd1);
    we0 = 0; clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("overflow_clr", 64'(oflw0), 64'd0);
`endif

    // Registered read: single read, then idle, then back-to-back
    cyc0(1'b0, 1'b1, '0);
    chk("rd0_data", dout0, fa(0));
    chk("rd0_valid", 64'(ov0), 64'd1);
    cyc0(1'b0, 1'b0, '0);
    chk("rd0_pulse", 64'(ov0), 64'd0);
    chk("rd0_hold", dout0, fa(0));
    for (int i = 1; i < 16; i++) begin
      cyc0(1'b0, 1'b1, '0);
      chk("rd_data", dout0, fa(i));
      chk("rd_valid", 64'(ov0), 64'd1);
    end
    cyc0(1'b0, 1'b0, '0);
    chk("drain_empty", 64'(empty0), 64'd1);
    chk("drain_valid", 64'(ov0), 64'd0);
    cyc0(1'b0, 1'b1, '0);
    chk("drop_rd_valid", 64'(ov0), 64'd0);
    chk("drop_rd_hold", dout0, fa(15));
    chk("drop_rd_level", 64'(lvl0), 64'd0);

    // Steady stream at level 5; 45 writes wrap the 16-entry pointers twice
    for (int i = 0; i < 5; i++) cyc0(1'b1, 1'b0, fc(i));
    for (int k = 0; k < 40; k++) begin
      cyc0(1'b1, 1'b1, fc(k + 5));
      chk("stream_level", 64'(lvl0), 64'd5);
      chk("stream_data", dout0, fc(k));
      chk("stream_valid", 64'(ov0), 64'd1);
    end
    for (int k = 40; k < 45; k++) begin
      cyc0(1'b0, 1'b1, '0);
      chk("stream_drain", dout0, fc(k));
    end
    chk("stream_empty", 64'(lvl0), 64'd0);

    // Full with both requests: only the read is accepted
    for (int i = 0; i < 16; i++) cyc0(1'b1, 1'b0, ff(i));
    cyc0(1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("fullboth_level", 64'(lvl0), 64'd15);
    chk("fullboth_data", dout0, ff(0));
    for (int i = 1; i < 16; i++) begin
      cyc0(1'b0, 1'b1, '0);
      chk("fullboth_drain", dout0, ff(i));
    end
    chk("fullboth_empty", 64'(empty0), 64'd1);
    // Empty with both requests: write only, nothing bypasses to the output
    cyc0(1'b1, 1'b1, 64'h5555_0000_AAAA_0001);
    chk("emptyboth_level", 64'(lvl0), 64'd1);
    chk("emptyboth_valid", 64'(ov0), 64'd0);
    chk("emptyboth_hold", dout0, ff(15));
    cyc0(1'b0, 1'b1, '0);
    chk("emptyboth_rd", dout0, 64'h5555_0000_AAAA_0001);

    // Asynchronous reset in the middle of a write burst at level 9
    for (int i = 0; i < 9; i++) cyc0(1'b1, 1'b0, fa(i + 100));
    chk("pre_rst_level", 64'(lvl0), 64'd9);
    we0 = 1'b1; din0 = fa(200);
    #3 rst = 1'b0;
    #1;
    chk("arst_level", 64'(lvl0), 64'd0);
    chk("arst_empty", 64'(empty0), 64'd1);
    chk("arst_ae", 64'(ae0), 64'd1);
    chk("arst_dout", dout0, 64'd0);
    chk("arst_valid", 64'(ov0), 64'd0);
    we0 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_level", 64'(lvl0), 64'd0);
    cyc0(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    cyc0(1'b0, 1'b1, '0);
    chk("post_rst_data", dout0, 64'h0123_4567_89AB_CDEF);
    chk("post_rst_valid", 64'(ov0), 64'd1);

    // FWFT, four channels
    chk("fw_empty", 64'(empty1), 64'd1);
    chk("fw_valid0", 64'(ov1), 64'd0);
    cyc1(1'b1, 1'b0, 64'h4444_3333_2222_1111);
    chk("fw_valid1", 64'(ov1), 64'd1);
    chk("fw_data1", dout1, 64'h4444_3333_2222_1111);
    chk("fw_level1", 64'(lvl1), 64'd1);
    cyc1(1'b1, 1'b0, 64'h8888_7777_6666_5555);
    chk("fw_head_kept", dout1, 64'h4444_3333_2222_1111);
    cyc1(1'b0, 1'b1, '0);
    chk("fw_pop_data", dout1, 64'h8888_7777_6666_5555);
    chk("fw_pop_level", 64'(lvl1), 64'd1);
    cyc1(1'b0, 1'b1, '0);
    chk("fw_pop_empty", 64'(empty1), 64'd1);
    chk("fw_pop_valid", 64'(ov1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
